// File: rtl/key_updown_display.sv
// rtl/key_updown_display.sv - two-key debounced up/down hex counter with multiplexed 7-segment scan
// Optional build macro: KEY_AUTOREPEAT_EN enables hold-to-repeat on a single held key.
module key_updown_display #(
  parameter int CLK_HZ          = 12_000_000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int SCAN_HZ         = 1000,
  parameter int DIGITS          = 2,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_up,
  input  logic                  key_down,
  output logic [4*DIGITS-1:0]   count,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [8:0]            seg_led
);

  localparam int DB_CYCLES   = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int SCAN_CYCLES = CLK_HZ / SCAN_HZ;
  localparam int DW          = $clog2(DB_CYCLES) + 1;
  localparam int PW          = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int IW          = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  // Repeat timing only matters when hold-to-repeat is built in; negative
  // values are meaningless in either build, so they fall into an empty block.
  if (REPEAT_DELAY_MS < 0 || REPEAT_RATE_MS < 0) begin : g_repeat_cfg_unused
  end

  // Key index 0 is up, index 1 is down throughout.
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         db;
  logic [1:0]         db_q;
  logic [1:0][DW-1:0] dcnt;
  logic [1:0]         press_ev;
  logic [1:0]         fire;

  logic [4*DIGITS-1:0] count_next;
  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_next;
  logic                scan_tick;
  logic [3:0]          nibble;
  logic [DIGITS-1:0]   sel_next;

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] f;
    f = 7'h00;
    case (v)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h39;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      4'hF: f = 7'h71;
      default: f = 7'h00;
    endcase
    return f;
  endfunction

  // Two-flop synchroniser per key; idles released (high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {key_down, key_up};
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after it has held for DB_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db   <= 2'b11;
      db_q <= 2'b11;
      dcnt <= '0;
    end else begin
      db_q <= db;
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] == db[k]) begin
          dcnt[k] <= '0;
        end else if (dcnt[k] == DB_LAST) begin
          db[k]   <= sync2[k];
          dcnt[k] <= '0;
        end else begin
          dcnt[k] <= dcnt[k] + 1'b1;
        end
      end
    end
  end

  assign press_ev = db_q & ~db;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [31:0] RD_CYCLES = 32'(CLK_HZ / 1000 * REPEAT_DELAY_MS);
  localparam logic [31:0] RR_CYCLES = 32'(CLK_HZ / 1000 * REPEAT_RATE_MS);

  logic [31:0] rcnt;
  logic        rphase;
  logic        one_held;
  logic        rep_hit;

  // rcnt counts cycles since the press event (or since the last repeat once
  // rphase is set); both keys held or both released restarts it.
  assign one_held = db[0] ^ db[1];
  assign rep_hit  = one_held && (rcnt == (rphase ? RR_CYCLES : RD_CYCLES));
  assign fire     = press_ev | ({2{rep_hit}} & ~db);

  // Repeat timer: initial delay first, then the fixed repeat interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt   <= '0;
      rphase <= 1'b0;
    end else if (!one_held) begin
      rcnt   <= '0;
      rphase <= 1'b0;
    end else if (rep_hit) begin
      rcnt   <= 32'd1;
      rphase <= 1'b1;
    end else begin
      rcnt   <= rcnt + 32'd1;
    end
  end
`else
  assign fire = press_ev;
`endif

  // Up and down in the same cycle cancel; otherwise step with wraparound.
  always_comb begin
    count_next = count;
    case (fire)
      2'b01:   count_next = count + 1'b1;
      2'b10:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  // Next scan digit: advance once per SCAN_CYCLES, wrapping at the last digit.
  always_comb begin
    scan_tick = (presc == PRESC_LAST);
    idx_next  = idx;
    if (scan_tick) begin
      idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
    nibble   = 4'(count >> (4 * idx_next));
    sel_next = ~(DIGITS'(1) << idx_next);
  end

  // Scan state plus registered display outputs, so select and segments move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      idx       <= '0;
      digit_sel <= ~DIGITS'(1);
      seg_led   <= 9'h03F;
    end else begin
      presc     <= scan_tick ? '0 : presc + 1'b1;
      idx       <= idx_next;
      digit_sel <= sel_next;
      seg_led   <= {2'b00, hex_font(nibble)};
    end
  end

endmodule

// File: doc/key_updown_display.md
# key_updown_display

Parametrised successor to the single-key hex counter. It takes two push keys (up and down), debounces both inside the clock domain with edge detection rather than clocking logic from key edges, and holds a wrapping counter of `4*DIGITS` bits. It drives a multiplexed common-cathode display of `DIGITS` hex digits through one shared 9-bit segment bus. It sits between the board keys and the 7-segment connector.

## Interface
Parameters:
- `CLK_HZ`, 12_000_000: system clock frequency.
- `DEBOUNCE_MS`, 20: stable time needed to accept a key level change. `DB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS`.
- `SCAN_HZ`, 1000: digit advance rate. `SCAN_CYCLES = CLK_HZ/SCAN_HZ`.
- `DIGITS`, 2: number of hex digits, 1..8.
- `REPEAT_DELAY_MS`, 500: hold time before the first auto-repeat. Used only when the macro is defined.
- `REPEAT_RATE_MS`, 100: interval between repeats. Used only when the macro is defined.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `key_up`, in, 1: raw key, active-low (0 = pressed), asynchronous to `clk`.
- `key_down`, in, 1: raw key, active-low, asynchronous to `clk`.
- `count`, out, `4*DIGITS`: current counter value.
- `digit_sel`, out, `DIGITS`: one-hot digit enable, active-low.
- `seg_led`, out, 9: segment pattern for the selected digit. Bits [6:0] = g..a, active-high. Bits [8:7] are always 0.

## Operation
- Every flop resets asynchronously on `rst`=1 and releases on the first `clk` after `rst`=0.
- Synchroniser: each key passes through a 2-flop synchroniser. Its reset value is 1 (released).
- Debouncer, one per key:
  - Debounced level `db` resets to 1.
  - Counter `dcnt` clears whenever the synchronised level equals `db`.
  - Otherwise `dcnt` increments. When `dcnt` reaches `DB_CYCLES-1`, `db` takes the synchronised level and `dcnt` clears.
  - Any glitch shorter than `DB_CYCLES` cycles is ignored.
- Press event: a 1-cycle pulse on the transition of `db` from 1 to 0. Releases generate no event.
- Counter update:
  - Up event alone: `count` + 1, wrapping from all-ones to 0.
  - Down event alone: `count` − 1, wrapping from 0 to all-ones.
  - Up and down events in the same cycle: no change.
  - Holding one key does not block events from the other key.
- Scan:
  - A prescaler counts to `SCAN_CYCLES-1`, then advances the digit index `idx` and wraps to 0.
  - `idx` wraps from `DIGITS-1` to 0.
  - `digit_sel = ~(1 << idx)`.
  - `seg_led = font(count[4*idx +: 4])`.
  - With `DIGITS`=1, `digit_sel` is constant 0.
- Font (hex digit 0..F to `seg_led`): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71.
- Reset values:
  - `count`=0.
  - `idx`=0, so `digit_sel` = all ones except bit0 = 0.
  - `seg_led`=9'h03F.
- Reset during a press: `db` returns to 1. A key still held after reset is accepted as one new press after `DB_CYCLES`.

## Timing
- `digit_sel` and `seg_led` are registered and change in the same cycle.
- `count` changes are visible on `seg_led` at the latest one cycle after the change, when that digit is selected.
- Press latency: the key goes low and stays low from the sampling edge at cycle 0.
  - Synchroniser output is low at cycle 2.
  - `db` falls at cycle 2+`DB_CYCLES`.
  - `count` updates at cycle 3+`DB_CYCLES`.
- Each digit is active for exactly `SCAN_CYCLES` cycles. The full frame is `DIGITS*SCAN_CYCLES` cycles.

## Configuration
- `KEY_AUTOREPEAT_EN` defined:
  - While exactly one key's `db` stays 0, an extra event of that key fires after `REPEAT_DELAY_MS`, then every `REPEAT_RATE_MS`. Both are measured from the original press event, in clock cycles computed like `DB_CYCLES`.
  - Release, or pressing the second key, stops repeats and resets the repeat timer.
- `KEY_AUTOREPEAT_EN` not defined:
  - One event per press, no repeat logic.
  - The repeat parameters are accepted but ignored.

## Test plan
Bench parameters: `CLK_HZ`=1000, `DEBOUNCE_MS`=4 (`DB_CYCLES`=4), `SCAN_HZ`=500 (`SCAN_CYCLES`=2), `DIGITS`=2.
- Reset with key_up held low:
  - `count`=0, `seg_led`=03F, `digit_sel`=2'b10 during reset.
  - After release of `rst`, `count`=1 exactly 7 cycles later.
- key_up low for 3 cycles, then high: no change to `count`, `db` stays 1.
- 255 clean key_up presses from 0: `count`=8'hFF, `seg_led` shows 71 on both digits. One more press gives `count`=8'h00.
- From `count`=8'h00, a clean key_down press gives 8'hFF. Both keys pressed in the same cycle leave `count`=8'hFF.
- `count`=8'h3A: `digit_sel` alternates 10/01 every 2 cycles, with `seg_led` 77 and 4F respectively.
- With `KEY_AUTOREPEAT_EN`, `REPEAT_DELAY_MS`=10, `REPEAT_RATE_MS`=5, key_up held 22 cycles beyond the first event: `count` goes 0→1, then 2 at +10, 3 at +15, 4 at +20.
